seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Parametrised time-multiplexed seven-segment display driver for the board-level debug path of the pipelined CPU. It replaces the fixed 4-digit divider/ring-counter/decoder chain with a generic scanner that drives any digit count and prescale ratio. It latches the input once per frame so a refresh never shows two different values, and adds leading-zero blanking, per-digit decimal points, an enable, and selectable output polarity. The selected debug word (PC, register contents) feeds `value`; the outputs go straight to board pins.

## Interface
- DIGITS, 4: number of digits scanned, legal 1..8.
- DIV, 100000: clk cycles per digit slot, legal 2..2^26.
- ACTIVE_LOW_SEG, 1: 1 = seg/dp pins active-low.
- ACTIVE_LOW_AN, 1: 1 = anode pins active-low.
- BLANK_LZ, 1: 1 = blank leading-zero digits.

- clk  in  1  system clock; one clock domain, all state on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan; 0 = display dark.
- value  in  4*DIGITS  hex value; nibble i drives digit i, digit 0 rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- an  out  DIGITS  digit anode selects, one-hot active when lit.
- seg  out  7  segments, seg[6]=a … seg[0]=g.
- dp  out  1  decimal point of the current digit.
- frame_done  out  1  one-cycle pulse when a new frame snapshot loads.

## Operation
- Prescaler `pcnt`, width clog2(DIV), counts 0..DIV-1 and wraps. `tick` = enable && pcnt==DIV-1.
- Digit index `idx` advances on `tick` and wraps from DIGITS-1 to 0.
- Shadow registers `sval` and `sdp` load `value` and `dp_in` on `tick` when idx==DIGITS-1, i.e. at frame wrap. `frame_done` is registered high for exactly that cycle.
- While enable=0:
  - pcnt and idx are held at 0.
  - sval/sdp load every cycle.
  - an, seg and dp are forced inactive.
  - frame_done stays 0.
- Decode, logical active-high abcdefg:
  - 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70
  - 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47
- Output polarity: seg and dp are inverted when ACTIVE_LOW_SEG=1; an is inverted when ACTIVE_LOW_AN=1.
- Blanking: with BLANK_LZ=1, digit i>0 is blanked when sval nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
  - A blanked slot has its anode inactive and seg/dp inactive.
  - The slot keeps its time; the scan period is unchanged.
- Lit slot: the anode for idx is active, seg = decode(sval[idx]), dp = sdp[idx].
- DIGITS=1: idx is constant 0, and every tick is a frame wrap.

## Timing
- Reset values: pcnt=0, idx=0, sval=0, sdp=0, frame_done=0. an, seg and dp are all inactive, e.g. an=4'hF and seg=7'h7F for the defaults.
- an, seg and dp are registered. They reflect the idx/sval/sdp state of the previous cycle, so there is 1-cycle latency after idx changes.
- After reset deassert with enable=1:
  - The first tick occurs on cycle DIV.
  - The first lit slot (digit 0, value 0) appears one cycle after reset release.
  - Each slot lasts exactly DIV cycles; the frame period is DIGITS*DIV.
- Snapshot timing: a change to value appears no later than one frame plus 1 cycle after the next frame wrap. No frame mixes old and new nibbles.
- Simultaneous tick and enable fall: enable wins. Counters clear and no snapshot or frame_done occurs.
- enable rise: scanning restarts at idx=0 with pcnt=0. Outputs light on the next cycle, using the value sampled on the last disabled cycle.
- Reset asserted mid-frame clears all state immediately, asynchronously; outputs go inactive without waiting for clk.

## Test plan
- Defaults with DIV=4, value=16'h12AF, dp_in=0, enable=1 → an cycles E,D,B,7 every 4 clk. seg (active-low) = ~47, ~77, ~6D, ~30. frame_done pulses every 16 clk.
- Blanking with value=16'h0005 → only digit 0 lit (an=E, seg=~5B); the other slots show an=F. value=0 → digit 0 shows "0"; with BLANK_LZ=0 all four digits are lit.
- Tear check: change value from 16'h1111 to 16'h2222 mid-frame → the remaining digits of that frame still show 1. The following frame shows all 2s, starting after the frame_done pulse.
- Deassert enable mid-scan → the next cycle shows an=F, seg=7F, dp=1. Reassert → digit 0 lit one cycle later, and the next tick comes DIV cycles after reassert.
- DIGITS=8, DIV=2, ACTIVE_LOW_SEG=0, ACTIVE_LOW_AN=0, dp_in=8'h80 → an walks 01..80. dp=1 only in the digit-7 slot. seg is active-high.
- Assert reset asynchronously mid-slot, between clk edges → outputs go inactive immediately. After release, scanning restarts at digit 0 showing "0".

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner: prescaled digit walk, per-frame snapshot,
// leading-zero blanking and selectable pin polarity. All outputs are registered.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 100000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN  ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;

  // Hex to logical active-high abcdefg.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h7E;
      4'h1: f_decode = 7'h30;
      4'h2: f_decode = 7'h6D;
      4'h3: f_decode = 7'h79;
      4'h4: f_decode = 7'h33;
      4'h5: f_decode = 7'h5B;
      4'h6: f_decode = 7'h5F;
      4'h7: f_decode = 7'h70;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h7B;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h1F;
      4'hC: f_decode = 7'h4E;
      4'hD: f_decode = 7'h3D;
      4'hE: f_decode = 7'h4F;
      4'hF: f_decode = 7'h47;
      default: f_decode = 7'h00;
    endcase
  endfunction

  logic [PW-1:0]         r_pcnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_sval;
  logic [DIGITS-1:0]     r_sdp;
  logic                  w_tick;
  logic                  w_wrap;
  logic [DIGITS-1:0]     w_zero_above;
  logic                  w_blank;
  logic [DIGITS-1:0]     w_an_nxt;
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;

  assign w_tick = enable && (r_pcnt == PW'(DIV - 1));
  assign w_wrap = w_tick && (r_idx == IW'(DIGITS - 1));

  // Prescaler, digit index and frame snapshot; disable holds counters and tracks the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt     <= '0;
      r_idx      <= '0;
      r_sval     <= '0;
      r_sdp      <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      r_pcnt     <= '0;
      r_idx      <= '0;
      r_sval     <= value;
      r_sdp      <= dp_in;
      frame_done <= 1'b0;
    end else begin
      r_pcnt     <= w_tick ? '0 : r_pcnt + PW'(1);
      frame_done <= w_wrap;
      if (w_wrap) begin
        r_idx  <= '0;
        r_sval <= value;
        r_sdp  <= dp_in;
      end else if (w_tick) begin
        r_idx  <= r_idx + IW'(1);
      end else begin
        r_idx  <= r_idx;
      end
    end
  end

  // w_zero_above[i] is set when nibbles i..DIGITS-1 of the snapshot are all zero.
  always_comb begin
    logic acc;
    acc          = 1'b1;
    w_zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc             = acc && (r_sval[4*i +: 4] == 4'h0);
      w_zero_above[i] = acc;
    end
  end

  assign w_blank = BLANK_LZ && (r_idx != '0) && w_zero_above[r_idx];

  // Next pin values in logical polarity, then mapped to the board polarity.
  always_comb begin
    if (enable && !w_blank) begin
      w_an_nxt  = DIGITS'(1) << r_idx;
      w_seg_nxt = f_decode(r_sval[4*r_idx +: 4]);
      w_dp_nxt  = r_sdp[r_idx];
    end else begin
      w_an_nxt  = '0;
      w_seg_nxt = 7'h00;
      w_dp_nxt  = 1'b0;
    end
  end

  // Registered pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= w_an_nxt ^ AN_OFF;
      seg <= w_seg_nxt ^ SEG_OFF;
      dp  <= w_dp_nxt ^ DP_OFF;
    end
  end

endmodule
